// File: rtl/snake_pkg.sv
// snake_pkg: shared map geometry, requester ids and VRAM write-arbiter types.
package snake_pkg;
  localparam int MAP_W = 75;
  localparam int MAP_H = 75;
  localparam int CELLS = MAP_W * MAP_H;
  localparam int AW = 13;
  localparam int DW = 16;
  localparam int REQ_A = 0;
  localparam int REQ_B = 1;
  localparam int REQ_FOOD = 2;
  localparam logic [DW-1:0] CLEAR_DATA = 16'h0000;
  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction
endpackage

// File: rtl/rr_arb3.sv
// rr_arb3: combinational 3-way round-robin arbiter; search starts just after pointer.
module rr_arb3
  import snake_pkg::*;
(
  input  logic [2:0] eligible,
  input  logic [1:0] pointer,
  output logic [2:0] grant,
  output logic [1:0] winner
);
  logic [1:0] c0, c1, c2;
  always_comb begin
    c0 = rr_next(pointer);
    c1 = rr_next(c0);
    c2 = rr_next(c1);
    winner = eligible[c0] ? c0 : eligible[c1] ? c1 : c2;
    grant = eligible[winner] ? 3'(1) << winner : 3'b000;
  end
endmodule

// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: owns the VRAM write port; round-robin among three writers,
// with a full-map clear sequencer that pre-empts them.
module vram_write_arbiter
  import snake_pkg::*;
(
  input  logic          pclk,
  input  logic          rstn,
  input  logic          clear_start,
  input  logic [2:0]    req,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] wdata2,
  output logic [2:0]    ack,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          clear_busy,
  output logic          clear_done,
  output logic          conflict
);
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, waddr_q, waddr_d, cnt_nxt, sel_addr;
  logic [DW-1:0] wdata_q, wdata_d, sel_data;
  logic [1:0] ptr_q, ptr_d, winner;
  logic [2:0] ack_q, ack_d, eligible, grant;
  logic we_q, we_d, busy_q, busy_d, done_q, done_d, conflict_q, conflict_d, coll;
  // A requester acked this cycle may still show req at the next edge; mask it out.
  assign eligible = req & ~ack_q;
  rr_arb3 u_arb (.eligible(eligible), .pointer(ptr_q), .grant(grant), .winner(winner));
  always_comb begin
    sel_addr = (winner == 2'(REQ_A)) ? addr0 : (winner == 2'(REQ_B)) ? addr1 : addr2;
    sel_data = (winner == 2'(REQ_A)) ? wdata0 : (winner == 2'(REQ_B)) ? wdata1 : wdata2;
    coll = (eligible[0] & eligible[1] & (addr0 == addr1)) |
           (eligible[0] & eligible[2] & (addr0 == addr2)) |
           (eligible[1] & eligible[2] & (addr1 == addr2));
    cnt_nxt = cnt_q + AW'(1);
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    ack_d = '0;
    we_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    busy_d = 1'b0;
    done_d = 1'b0;
    conflict_d = 1'b0;
    if (state_q == IDLE) begin
      conflict_d = coll;
      if (clear_start) begin
        state_d = CLEAR;
        cnt_d = '0;
        we_d = 1'b1;
        waddr_d = '0;
        wdata_d = CLEAR_DATA;
        busy_d = 1'b1;
      end else if (grant != 3'b000) begin
        ack_d = grant;
        ptr_d = winner;
        we_d = 1'b1;
        waddr_d = sel_addr;
        wdata_d = sel_data;
      end
    end else if (state_q == CLEAR) begin
      // cnt_q is the cell being written in the current cycle; issue the next one.
      cnt_d = cnt_nxt;
      we_d = 1'b1;
      waddr_d = cnt_nxt;
      wdata_d = CLEAR_DATA;
      busy_d = 1'b1;
      state_d = (cnt_nxt == LAST_CELL) ? DONE : CLEAR;
    end else begin
      done_d = 1'b1;
      cnt_d = '0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ptr_q <= 2'd2;
      ack_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      ack_q <= ack_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q <= busy_d;
      done_q <= done_d;
      conflict_q <= conflict_d;
    end
  end
  assign ack = ack_q;
  assign we = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign clear_busy = busy_q;
  assign clear_done = done_q;
  assign conflict = conflict_q;
endmodule
